alu_arbiter: RTL and testbench

Shares the single integer ALU between up to NREQ requesters (for example the execute stage, a multi-cycle mul/div sequencer and a debug port) using a round-robin grant. Each transaction is a three-phase handshake: accept, execute, respond. The block drives the ALU operand and control inputs from registers and captures the ALU result into a held response register. It sits beside the ALU in the execute region; the ALU itself is instantiated outside this block.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/rr_picker.sv | 31 +++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and arbiter state encoding.
package alu_pkg;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Codes outside this set fall through to the ALU's XOR default.
  function automatic logic aluc_is_known(input logic [3:0] aluc);
    return (aluc == ALUC_AND) || (aluc == ALUC_OR) ||
           (aluc == ALUC_ADD) || (aluc == ALUC_SUB);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  logic found;
  int   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU; accept -> execute -> respond per transaction.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [4*NREQ-1:0]    req_aluc,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_aluc,
  input  logic [31:0]          alu_r,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_r
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [3:0]      alu_aluc_q, alu_aluc_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_r_q, rsp_r_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic [31:0]     opa [NREQ];
  logic [31:0]     opb [NREQ];
  logic [3:0]      opc [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opa[i] = req_a[32*i +: 32];
    assign opb[i] = req_b[32*i +: 32];
    assign opc[i] = req_aluc[4*i +: 4];
  end

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Ready is only offered while idle, so at most one transaction is ever in flight.
  assign req_ready = (state_q == ST_IDLE) ? pick_gnt : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_aluc_d  = alu_aluc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    case (state_q)
      ST_IDLE: begin
        if (|pick_gnt) begin
          alu_a_d    = opa[pick_idx];
          alu_b_d    = opb[pick_idx];
          alu_aluc_d = opc[pick_idx];
          gidx_d     = pick_idx;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_r_d     = alu_r;
        rsp_id_d    = IDW'(gidx_q);
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Pointer moves past the served requester only once its response is taken.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_aluc_q  <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_aluc_q  <= alu_aluc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_aluc  = alu_aluc_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;

  localparam int N   = 4;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             clrn;
  logic [N-1:0]     reqValid;
  logic [32*N-1:0]  reqA, reqB;
  logic [4*N-1:0]   reqAluc;
  logic [N-1:0]     reqReady;
  logic [31:0]      aluA, aluB, aluR, rspR;
  logic [3:0]       aluAluc;
  logic             rspValid, rspReady;
  logic [IDW-1:0]   rspId;

  int testsRun = 0;
  int testsFailed = 0;

  int          mPtr;
  bit          txOpen;
  int          txAge, txId;
  logic [31:0] txRes, txA, txB;
  logic [3:0]  txC;
  logic [31:0] obsRsp;
  int          grantLog[$];

  always #5 clk = ~clk;

  // The ALU lives outside the arbiter, so the bench provides it.
  function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0001: return a | b;
      4'b0000: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign aluR = aluFn(aluA, aluB, aluAluc);

  alu_arbiter #(.NREQ(N), .IDW(IDW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid (reqValid),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_aluc  (reqAluc),
    .req_ready (reqReady),
    .alu_a     (aluA),
    .alu_b     (aluB),
    .alu_aluc  (aluAluc),
    .alu_r     (aluR),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_id    (rspId),
    .rsp_r     (rspR)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pickModel(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    reqA[32*i +: 32] = a;
    reqB[32*i +: 32] = b;
    reqAluc[4*i +: 4] = c;
  endtask

  task automatic applyStimulus();
    reqValid = N'($urandom);
    for (int i = 0; i < N; i++) setReq(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
    rspReady = ($urandom_range(0, 3) != 0);
  endtask

  // One cycle: compare at the falling edge, then advance the model across the rising edge.
  task automatic stepCycle();
    int g;
    logic [N-1:0] expReady;
    @(negedge clk);
    g = txOpen ? -1 : pickModel(reqValid, mPtr);
    expReady = (g >= 0) ? (N'(1) << g) : '0;
    checkOutput("req_ready", reqReady, expReady);
    checkOutput("rsp_valid", rspValid, txOpen && txAge >= 1);
    if (txOpen && txAge == 0) begin
      checkOutput("alu_a", aluA, txA);
      checkOutput("alu_b", aluB, txB);
      checkOutput("alu_aluc", aluAluc, txC);
    end
    if (txOpen && txAge >= 1) begin
      checkOutput("rsp_r", rspR, txRes);
      checkOutput("rsp_id", rspId, txId);
      if (rspReady) obsRsp = rspR;
    end
    @(posedge clk);
    if (txOpen) begin
      if (txAge >= 1 && rspReady) begin
        txOpen = 1'b0;
        mPtr = (txId + 1) % N;
      end else begin
        txAge++;
      end
    end else if (g >= 0) begin
      txOpen = 1'b1;
      txAge = 0;
      txId = g;
      txA = reqA[32*g +: 32];
      txB = reqB[32*g +: 32];
      txC = reqAluc[4*g +: 4];
      txRes = aluFn(txA, txB, txC);
      grantLog.push_back(g);
    end
    #1;
  endtask

  task automatic applyReset();
    clrn = 1'b0;
    #2;
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_rsp_r", rspR, 0);
    checkOutput("rst_rsp_id", rspId, 0);
    checkOutput("rst_alu_a", aluA, 0);
    checkOutput("rst_alu_b", aluB, 0);
    checkOutput("rst_alu_aluc", aluAluc, 0);
    checkOutput("rst_req_ready", reqReady,
                (pickModel(reqValid, 0) >= 0) ? (N'(1) << pickModel(reqValid, 0)) : '0);
    txOpen = 1'b0;
    mPtr = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  task automatic drainIdle();
    reqValid = '0;
    rspReady = 1'b1;
    for (int i = 0; i < 10 && txOpen; i++) stepCycle();
  endtask

  initial begin
    int n;
    clrn = 1'b0;
    reqValid = '0;
    reqA = '0;
    reqB = '0;
    reqAluc = '0;
    rspReady = 1'b1;
    #1;
    applyReset();

    // Single add from requester 1.
    setReq(1, 32'h5, 32'h3, 4'b0010);
    reqValid = 4'b0010;
    #1;
    checkOutput("add_ready", reqReady, 4'b0010);
    stepCycle();
    reqValid = '0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("add_result", obsRsp, 32'h8);

    // All requesters valid continuously from reset.
    reqValid = 4'hF;
    for (int i = 0; i < N; i++) setReq(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
    applyReset();
    grantLog.delete();
    for (int i = 0; i < 15; i++) stepCycle();
    checkOutput("rr_count", grantLog.size(), 5);
    for (int k = 0; k < 5; k++) checkOutput($sformatf("rr_order_%0d", k), grantLog[k], k % N);

    // Backpressure on a SUB result while others keep requesting.
    drainIdle();
    for (int i = 0; i < N; i++) setReq(i, 32'h0, 32'h1, 4'b0110);
    reqValid = 4'hF;
    rspReady = 1'b0;
    stepCycle();
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("bp_hold", rspR, 32'hFFFF_FFFF);
    end
    n = grantLog.size();
    rspReady = 1'b1;
    stepCycle();
    checkOutput("bp_no_early_grant", grantLog.size(), n);
    stepCycle();
    checkOutput("bp_next_grant", grantLog.size(), n + 1);

    // Unrecognised control code falls through to XOR.
    drainIdle();
    setReq(3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1111);
    reqValid = 4'b1000;
    stepCycle();
    reqValid = '0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("xor_default", obsRsp, 32'hFF00_FF00);

    // Requester 2 appears for one cycle during RESP and withdraws.
    drainIdle();
    setReq(1, $urandom, $urandom, 4'b0001);
    reqValid = 4'b0010;
    rspReady = 1'b0;
    stepCycle();
    n = grantLog.size();
    reqValid = '0;
    stepCycle();
    reqValid = 4'b0100;
    stepCycle();
    reqValid = '0;
    rspReady = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("withdrawn_no_grant", grantLog.size(), n);

    // Reset while a transaction is in EXEC.
    drainIdle();
    setReq(2, $urandom, $urandom, 4'b0010);
    reqValid = 4'b0100;
    stepCycle();
    applyReset();
    grantLog.delete();
    reqValid = 4'hF;
    stepCycle();
    checkOutput("post_reset_grant", grantLog.size() > 0 ? grantLog[0] : -1, 0);
    for (int i = 0; i < 3; i++) stepCycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
